// File: rtl/y86_run_ctrl.sv
// Run controller for a Y86 SEQ core: program load, free run, single step,
// breakpoint pause, watchdog and status-driven halt. cpu_en gates all core commits.
module y86_run_ctrl #(
   parameter logic [63:0] RESET_PC   = 64'h0,
   parameter logic [31:0] WDOG_LIMIT = 32'd0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        step,
   input  logic        stop,
   input  logic [1:0]  stat,
   input  logic [63:0] pc,
   input  logic        bp_en,
   input  logic [63:0] bp_addr,
   output logic        cpu_en,
   output logic        pc_load,
   output logic [63:0] pc_init,
   output logic [2:0]  ctrl_state,
   output logic        busy,
   output logic        done,
   output logic [1:0]  final_stat,
   output logic        bp_hit,
   output logic        wdog,
   output logic [31:0] cycle_count
);

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StLoad  = 3'd1,
      StRun   = 3'd2,
      StStep  = 3'd3,
      StPause = 3'd4,
      StHalt  = 3'd5
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] cycle_count_q, cycle_count_d;
   logic [1:0]  final_stat_q, final_stat_d;
   logic        bp_hit_q, bp_hit_d;
   logic        wdog_q, wdog_d;
   logic        bp_skip_q, bp_skip_d;

   logic stat_ok;
   logic wdog_expired;
   logic bp_match;

   assign stat_ok      = (stat == 2'b00);
   assign wdog_expired = (WDOG_LIMIT != 32'd0) && (cycle_count_q == WDOG_LIMIT);
   // bp_skip lets a resumed run step past the breakpoint it stopped on
   assign bp_match     = bp_en && (pc == bp_addr) && !bp_skip_q;

   // Next-state, flag updates and the commit enable; exit checks in priority order
   always_comb begin
      state_d       = state_q;
      final_stat_d  = final_stat_q;
      bp_hit_d      = bp_hit_q;
      wdog_d        = wdog_q;
      bp_skip_d     = bp_skip_q;
      cpu_en        = 1'b0;
      cycle_count_d = cycle_count_q;
      case (state_q)
         StIdle: begin
            if (start) state_d = StLoad;
         end
         StLoad: begin
            state_d   = StRun;
            bp_hit_d  = 1'b0;
            wdog_d    = 1'b0;
            bp_skip_d = 1'b1;
         end
         StRun: begin
            if (!stat_ok) begin
               state_d      = StHalt;
               final_stat_d = stat;
            end else if (wdog_expired) begin
               state_d      = StHalt;
               wdog_d       = 1'b1;
               final_stat_d = stat;
            end else if (bp_match) begin
               state_d  = StPause;
               bp_hit_d = 1'b1;
            end else if (stop) begin
               state_d  = StPause;
               bp_hit_d = 1'b0;
            end else begin
               cpu_en    = 1'b1;
               bp_skip_d = 1'b0;
            end
         end
         StStep: begin
            if (stat_ok) begin
               cpu_en  = 1'b1;
               state_d = StPause;
            end else begin
               state_d      = StHalt;
               final_stat_d = stat;
            end
         end
         StPause: begin
            if (start) begin
               state_d   = StRun;
               bp_skip_d = 1'b1;
               bp_hit_d  = 1'b0;
            end else if (step) begin
               state_d  = StStep;
               bp_hit_d = 1'b0;
            end
         end
         StHalt: begin
            if (start) state_d = StLoad;
         end
         default: state_d = StIdle;
      endcase

      // Saturating count of committed cycles; cleared at program load
      if (state_q == StLoad) begin
         cycle_count_d = 32'd0;
      end else if (cpu_en && !(&cycle_count_q)) begin
         cycle_count_d = cycle_count_q + 32'd1;
      end
   end

   // State and flag registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= StIdle;
         cycle_count_q <= 32'd0;
         final_stat_q  <= 2'b00;
         bp_hit_q      <= 1'b0;
         wdog_q        <= 1'b0;
         bp_skip_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         cycle_count_q <= cycle_count_d;
         final_stat_q  <= final_stat_d;
         bp_hit_q      <= bp_hit_d;
         wdog_q        <= wdog_d;
         bp_skip_q     <= bp_skip_d;
      end
   end

   assign pc_load     = (state_q == StLoad);
   assign pc_init     = RESET_PC;
   assign ctrl_state  = state_q;
   assign busy        = (state_q == StLoad) || (state_q == StRun) || (state_q == StStep);
   assign done        = (state_q == StHalt);
   assign final_stat  = final_stat_q;
   assign bp_hit      = bp_hit_q;
   assign wdog        = wdog_q;
   assign cycle_count = cycle_count_q;

endmodule

// File: doc/y86_run_ctrl.md
Y86_RUN_CTRL -- requirements
Module: y86_run_ctrl

Interface
REQ-001 SHALL provide parameters, one per line: name, default, meaning.
- RESET_PC, 64'h0, PC value loaded into the SEQ core at program start.
- WDOG_LIMIT, 32'd0, maximum enabled cycles per run; 0 disables the watchdog.

REQ-002 SHALL provide ports, one per line: name, direction, width, meaning.
- clk, input, 1, single clock for the SEQ core and controller.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, begin a run (IDLE/HALT) or resume (PAUSE).
- step, input, 1, execute exactly one instruction from PAUSE.
- stop, input, 1, pause request.
- stat, input, 2, core Status: 00 AOK, 01 HLT, 10 ADR, 11 INS.
- pc, input, 64, core PC of the instruction about to execute.
- bp_en, input, 1, breakpoint enable.
- bp_addr, input, 64, breakpoint PC.
- cpu_en, output, 1, combinational; the core commits state (PC, registers, CC, memory) only on edges where it is 1.
- pc_load, output, 1, core loads pc_init on this edge.
- pc_init, output, 64, constant RESET_PC.
- ctrl_state, output, 3, current state encoding.
- busy, output, 1, state is LOAD, RUN or STEP.
- done, output, 1, state is HALT.
- final_stat, output, 2, stat captured on entry to HALT.
- bp_hit, output, 1, last pause was caused by the breakpoint.
- wdog, output, 1, last halt was caused by the watchdog.
- cycle_count, output, 32, enabled cycles in the current run.

Function
REQ-003 SHALL implement states IDLE=0, LOAD=1, RUN=2, STEP=3, PAUSE=4, HALT=5; encodings 6 and 7 SHALL go to IDLE on the next edge.
REQ-004 IDLE: start=1 -> LOAD; step and stop SHALL be ignored.
REQ-005 LOAD: lasts one cycle with pc_load=1 and cpu_en=0; clears cycle_count, bp_hit and wdog; sets bp_skip; -> RUN.
REQ-006 RUN: cpu_en=1 unless an exit condition holds that cycle; evaluation order (first match wins):
- stat!=00 -> HALT, final_stat=stat, cpu_en=0.
- WDOG_LIMIT!=0 and cycle_count==WDOG_LIMIT -> HALT, wdog=1, final_stat=stat, cpu_en=0.
- bp_en and pc==bp_addr and !bp_skip -> PAUSE, bp_hit=1, cpu_en=0; the breakpointed instruction does not execute.
- stop=1 -> PAUSE, bp_hit=0, cpu_en=0.
REQ-007 bp_skip SHALL clear after the first enabled cycle in RUN, so a run resumed at the breakpoint PC executes that instruction once.
REQ-008 PAUSE: cpu_en=0. start -> RUN with bp_skip set; otherwise step -> STEP. start and step together -> RUN. stop is ignored.
REQ-009 STEP: lasts one cycle. If stat==00, cpu_en=1 and the state goes to PAUSE; otherwise cpu_en=0, the state goes to HALT and final_stat=stat. Breakpoint and watchdog are ignored in STEP.
REQ-010 HALT: done=1 and cpu_en=0. start -> LOAD (restart); all other inputs are ignored.
REQ-011 cycle_count SHALL increment on every edge with cpu_en=1 and saturate at 32'hFFFF_FFFF; it holds in PAUSE and HALT.
REQ-012 start in RUN or STEP SHALL be ignored; stop in STEP SHALL be ignored.
REQ-013 final_stat, bp_hit and wdog SHALL hold until the next LOAD, except that bp_hit clears on leaving PAUSE.
REQ-014 All state and flags SHALL be registered; cpu_en, busy, done and pc_load SHALL be decoded from state and current inputs with no added latency.

Reset
REQ-015 rst_n=0 SHALL asynchronously force IDLE with cpu_en=0, pc_load=0, cycle_count=0, final_stat=00, bp_hit=0, wdog=0 and bp_skip=0.
REQ-016 Reset asserted mid-run SHALL drop cpu_en in the same cycle, with no further core commits.
REQ-017 After deassertion the block SHALL remain in IDLE until start.

Verification
REQ-018 start pulse, stat=00 for 10 cycles then stat=01 -> LOAD for 1 cycle; RUN with cpu_en=1 for 10 cycles; then done=1, final_stat=01, cycle_count=10.
REQ-019 bp_en=1, bp_addr=64'h14, pc reaches 64'h14 -> cpu_en=0 that cycle, PAUSE, bp_hit=1; then start -> the instruction at 64'h14 commits once and RUN continues.
REQ-020 In PAUSE, three step pulses -> exactly three cpu_en=1 cycles; cycle_count increases by 3; the state returns to PAUSE each time.
REQ-021 WDOG_LIMIT=5 with stat held at 00 -> 5 enabled cycles, then HALT, wdog=1, final_stat=00.
REQ-022 rst_n pulled low in RUN at cycle 4 -> cpu_en=0 immediately; after release ctrl_state=0 and cycle_count=0.
REQ-023 stat=10 on the first RUN cycle -> cpu_en never asserts, HALT, final_stat=10, cycle_count=0; then start -> LOAD, and the flags clear.
